// File: rtl/pingpong_pkg.sv
// Shared constants, FSM encoding and length helper for the ping-pong address generator.
// Optional tick generator is enabled with PINGPONG_TICK_GEN_EN.
package pingpong_pkg;

    localparam int LEN_W_DEF = 11;
    localparam int DIV_DEF   = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // A zero-length frame would never swap, so it is treated as one sample.
    function automatic logic [31:0] clamp_len(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/pingpong_tick_div.sv
// Divide-by-DIV sample tick and clk_c square wave, held at zero while disabled.
// Instantiated only when PINGPONG_TICK_GEN_EN is defined.
module pingpong_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic clk_c
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            clk_c <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            clk_c <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            clk_c <= ~clk_c;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pingpong_addr_gen.sv
// Ping-pong address generator for the dual-bank ECG sample BRAM.
// Define PINGPONG_TICK_GEN_EN to replace wr_en with an internal divide-by-DIV tick.
module pingpong_addr_gen
    import pingpong_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ADDR_W = LEN_W + 1,
    parameter int DIV    = DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  load,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic              switch,
    output logic              swap_pulse,
    output logic              rd_done,
    output logic              overrun,
    output logic              busy,
    output logic              clk_c
);

    if (ADDR_W != LEN_W + 1) begin : g_bad_addr_w
        $error("ADDR_W must equal LEN_W+1");
    end
    if (DIV < 2) begin : g_bad_div
        $error("DIV must be at least 2");
    end

    logic [1:0]       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_prev;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic             bank;
    logic             we;
    logic             wr_ev;
    logic             swap;
    logic [LEN_W-1:0] load_c;

`ifdef PINGPONG_TICK_GEN_EN
    logic tick;
    logic unused_wr_en;

    assign unused_wr_en = wr_en;

    pingpong_tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .tick  (tick),
        .clk_c (clk_c)
    );

    assign we = tick;
`else
    assign we    = wr_en;
    assign clk_c = 1'b0;
`endif

    assign busy   = (state != IDLE);
    assign wr_ev  = busy && we;
    assign swap   = wr_ev && (wr_cnt == len - 1'b1);
    assign load_c = LEN_W'(clamp_len(32'(load)));

    assign switch = bank;
    assign addra  = {bank, wr_cnt};
    assign addrb  = {~bank, rd_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            len_prev   <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            bank       <= 1'b0;
            swap_pulse <= 1'b0;
            rd_done    <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            swap_pulse <= swap;
            if (state == IDLE && start) begin
                state   <= RUN;
                len     <= load_c;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                overrun <= 1'b0;
            end else if (swap) begin
                // The swap restarts both sides; a same-cycle rd_en is dropped.
                wr_cnt   <= '0;
                rd_cnt   <= '0;
                bank     <= ~bank;
                len_prev <= len;
                len      <= load_c;
                rd_done  <= 1'b0;
                overrun  <= overrun | ~rd_done;
                if (state == DRAIN || stop)
                    state <= IDLE;
            end else begin
                if (wr_ev)
                    wr_cnt <= wr_cnt + 1'b1;
                if (state == RUN && stop)
                    state <= DRAIN;
                if (rd_en && !rd_done) begin
                    if (rd_cnt == len_prev - 1'b1)
                        rd_done <= 1'b1;
                    else
                        rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule
